// File: rtl/conv3x3_window_gen_if.sv
// Stream bundle between the pixel source, conv3x3_window_gen and the 3x3 kernel array.
// WIN_FRAME_CNT_EN adds the frame_cnt / m_first sideband signals.
interface conv3x3_window_gen_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_pixel;
    logic              s_valid;
    logic              s_ready;

    logic [DATA_W-1:0] win00, win01, win02;
    logic [DATA_W-1:0] win10, win11, win12;
    logic [DATA_W-1:0] win20, win21, win22;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
`ifdef WIN_FRAME_CNT_EN
    logic [15:0]       frame_cnt;
    logic              m_first;
`endif

    // Environment side: drives pixels in and takes windows out
    modport master (
`ifdef WIN_FRAME_CNT_EN
        input  frame_cnt, m_first,
`endif
        output s_pixel, s_valid, m_ready,
        input  s_ready,
        input  win00, win01, win02, win10, win11, win12, win20, win21, win22,
        input  m_valid, m_last
    );

    modport slave (
`ifdef WIN_FRAME_CNT_EN
        output frame_cnt, m_first,
`endif
        input  s_pixel, s_valid, m_ready,
        output s_ready,
        output win00, win01, win02, win10, win11, win12, win20, win21, win22,
        output m_valid, m_last
    );
endinterface

// File: rtl/conv3x3_window_gen.sv
// Builds 3x3 neighbourhoods from a raster pixel stream using two line buffers and a shift window.
// Optional macro WIN_FRAME_CNT_EN adds a consumed-frame counter and a first-window flag.
module conv3x3_window_gen #(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv3x3_window_gen_if.slave   bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [DATA_W-1:0] r_lbA [0:IMG_WIDTH-1];
    logic [DATA_W-1:0] r_lbB [0:IMG_WIDTH-1];
    logic [DATA_W-1:0] r_sw  [0:2][0:2];
    logic [DATA_W-1:0] r_win [0:2][0:2];
    logic              r_mValid;
    logic              r_mLast;

    logic              w_sReady;
    logic              w_accept;
    logic              w_winHit;
    logic              w_lastPos;
    logic [DATA_W-1:0] w_lbA;
    logic [DATA_W-1:0] w_lbB;
    logic [DATA_W-1:0] w_newCol [0:2];

    assign w_sReady  = ~r_mValid | bus.m_ready;
    assign w_accept  = bus.s_valid & w_sReady;
    assign w_lbA     = r_lbA[r_col];
    assign w_lbB     = r_lbB[r_col];
    assign w_winHit  = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
    assign w_lastPos = (r_row == ROW_LAST) && (r_col == COL_LAST);

    always_comb begin
        w_newCol[0] = w_lbB;
        w_newCol[1] = w_lbA;
        w_newCol[2] = bus.s_pixel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Line buffers are plain RAM: the combinational read above sees the old word
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lbB[r_col] <= w_lbA;
            r_lbA[r_col] <= bus.s_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_sw[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_sw[i][0] <= r_sw[i][1];
                r_sw[i][1] <= r_sw[i][2];
                r_sw[i][2] <= w_newCol[i];
            end
        end
    end

    // Output loads the post-shift window; a producing accept cannot occur while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
        end else if (w_winHit) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_sw[i][1];
                r_win[i][1] <= r_sw[i][2];
                r_win[i][2] <= w_newCol[i];
            end
            r_mValid <= 1'b1;
            r_mLast  <= w_lastPos;
        end else if (r_mValid && bus.m_ready) begin
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
        end
    end

`ifdef WIN_FRAME_CNT_EN
    logic [15:0] r_frameCnt;
    logic        r_mFirst;
    logic        w_firstPos;

    assign w_firstPos = (r_row == ROW_TWO) && (r_col == COL_TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frameCnt <= '0;
            r_mFirst   <= 1'b0;
        end else begin
            if (r_mValid && bus.m_ready && r_mLast) begin
                r_frameCnt <= r_frameCnt + 16'd1;
            end
            if (w_winHit) begin
                r_mFirst <= w_firstPos;
            end else if (r_mValid && bus.m_ready) begin
                r_mFirst <= 1'b0;
            end
        end
    end

    assign bus.frame_cnt = r_frameCnt;
    assign bus.m_first   = r_mFirst;
`endif

    assign bus.s_ready = w_sReady;
    assign bus.m_valid = r_mValid;
    assign bus.m_last  = r_mLast;
    assign bus.win00   = r_win[0][0];
    assign bus.win01   = r_win[0][1];
    assign bus.win02   = r_win[0][2];
    assign bus.win10   = r_win[1][0];
    assign bus.win11   = r_win[1][1];
    assign bus.win12   = r_win[1][2];
    assign bus.win20   = r_win[2][0];
    assign bus.win21   = r_win[2][1];
    assign bus.win22   = r_win[2][2];
endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Scoreboard bench for conv3x3_window_gen: a 4x4 instance for directed frames and a 6x5 instance for random traffic.
// Expected windows come from a frame-image reference model; a negedge monitor pops and compares.
module tb_conv3x3_window_gen;
    localparam int DW = 8;

    typedef struct packed {
        logic [8:0][DW-1:0] w;
        logic               last;
        logic               first;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [DW-1:0] pix  [2];
    logic          vld  [2];
    logic          mRdy [2];
    logic          randOn = 1'b0;

    conv3x3_window_gen_if #(.DATA_W(DW)) bus4 ();
    conv3x3_window_gen_if #(.DATA_W(DW)) bus6 ();

    conv3x3_window_gen #(.DATA_W(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4));
    conv3x3_window_gen #(.DATA_W(DW), .IMG_WIDTH(6), .IMG_HEIGHT(5)) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6));

    assign bus4.s_pixel = pix[0];
    assign bus4.s_valid = vld[0];
    assign bus4.m_ready = mRdy[0];
    assign bus6.s_pixel = pix[1];
    assign bus6.s_valid = vld[1];
    assign bus6.m_ready = mRdy[1];

    wire                sRdy [2];
    wire                mVld [2];
    wire                mLst [2];
    wire [8:0][DW-1:0]  winOut [2];
    assign sRdy[0] = bus4.s_ready;
    assign sRdy[1] = bus6.s_ready;
    assign mVld[0] = bus4.m_valid;
    assign mVld[1] = bus6.m_valid;
    assign mLst[0] = bus4.m_last;
    assign mLst[1] = bus6.m_last;
    assign winOut[0] = {bus4.win22, bus4.win21, bus4.win20, bus4.win12, bus4.win11,
                        bus4.win10, bus4.win02, bus4.win01, bus4.win00};
    assign winOut[1] = {bus6.win22, bus6.win21, bus6.win20, bus6.win12, bus6.win11,
                        bus6.win10, bus6.win02, bus6.win01, bus6.win00};

    int total = 0;
    int bad   = 0;
    int winCnt [2] = '{0, 0};
    int frameExp = 0;

    logic [DW-1:0] img [2][8][8];
    int mr [2] = '{0, 0};
    int mc [2] = '{0, 0};
    exp_t q0 [$];
    exp_t q1 [$];

    logic               prevStall [2] = '{1'b0, 1'b0};
    logic [8:0][DW-1:0] held [2];
    exp_t               eMon;

    function automatic int widthOf(input int s);
        return (s == 0) ? 4 : 6;
    endfunction

    function automatic int heightOf(input int s);
        return (s == 0) ? 4 : 5;
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: store the frame as an image and cut the 3x3 patch ending at (r,c)
    task automatic modelPixel(input int s, input logic [DW-1:0] p);
        exp_t e;
        img[s][mr[s]][mc[s]] = p;
        if (mr[s] >= 2 && mc[s] >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.w[i*3+j] = img[s][mr[s]-2+i][mc[s]-2+j];
            e.last  = (mr[s] == heightOf(s) - 1) && (mc[s] == widthOf(s) - 1);
            e.first = (mr[s] == 2) && (mc[s] == 2);
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        mc[s]++;
        if (mc[s] == widthOf(s)) begin
            mc[s] = 0;
            mr[s]++;
            if (mr[s] == heightOf(s)) mr[s] = 0;
        end
    endtask

    task automatic modelReset();
        mr = '{0, 0};
        mc = '{0, 0};
        q0.delete();
        q1.delete();
        frameExp = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel is accepted
    task automatic applyStimulus(input int s, input logic [DW-1:0] p, input int gapPct);
        bit acc = 0;
        while ($urandom_range(99) < gapPct) begin
            @(posedge clk); #1;
        end
        pix[s] = p;
        vld[s] = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (sRdy[s]) begin
                acc = 1;
                modelPixel(s, p);
            end
            @(posedge clk); #1;
        end
        vld[s] = 1'b0;
        if (!acc) checkOutput($sformatf("s_ready_timeout_dut%0d", s), 72'd0, 72'd1);
    endtask

    task automatic waitDrain(input int s);
        int n = 0;
        while (((s == 0) ? q0.size() : q1.size()) > 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput($sformatf("drain_dut%0d", s), (s == 0) ? q0.size() : q1.size(), 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_m_valid", mVld[0], 0);
        checkOutput("rst_m_last", mLst[0], 0);
        checkOutput("rst_win_dut4", winOut[0], 0);
        checkOutput("rst_win_dut6", winOut[1], 0);
        modelReset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("s_ready_after_rst_dut4", sRdy[0], 1);
        checkOutput("s_ready_after_rst_dut6", sRdy[1], 1);
    endtask

    // Monitor: compare every consumed window against the scoreboard, and hold during stalls
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst_n) begin
                prevStall[s] = 1'b0;
            end else if (mVld[s] && !mRdy[s]) begin
                checkOutput($sformatf("s_ready_stall_dut%0d", s), sRdy[s], 0);
                if (prevStall[s]) checkOutput($sformatf("hold_dut%0d", s), winOut[s], held[s]);
                held[s]      = winOut[s];
                prevStall[s] = 1'b1;
            end else if (mVld[s] && mRdy[s]) begin
                prevStall[s] = 1'b0;
                if (((s == 0) ? q0.size() : q1.size()) == 0) begin
                    checkOutput($sformatf("extra_window_dut%0d", s), winOut[s], 72'hx);
                end else begin
                    eMon = (s == 0) ? q0.pop_front() : q1.pop_front();
                    checkOutput($sformatf("window_dut%0d", s), winOut[s], eMon.w);
                    checkOutput($sformatf("m_last_dut%0d", s), mLst[s], eMon.last);
                    winCnt[s]++;
`ifdef WIN_FRAME_CNT_EN
                    if (s == 0) begin
                        checkOutput("m_first", bus4.m_first, eMon.first);
                        checkOutput("frame_cnt", bus4.frame_cnt, frameExp);
                        if (eMon.last) frameExp++;
                    end
`endif
                end
            end else begin
                prevStall[s] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (randOn) mRdy[1] = 1'($urandom_range(1));
    end

    initial begin
        int base;
        bit seen;
        rst_n = 1'b0;
        pix   = '{0, 0};
        vld   = '{1'b0, 1'b0};
        mRdy  = '{1'b1, 1'b1};
        @(posedge clk); #1;
        doReset();

        $display("[TB] basic 4x4 frame");
        base = winCnt[0];
        for (int p = 0; p < 16; p++) applyStimulus(0, 8'(p), 0);
        waitDrain(0);
        checkOutput("basic_count", winCnt[0] - base, 4);

        $display("[TB] backpressure");
        base = winCnt[0];
        fork
            begin
                for (int p = 0; p < 16; p++) applyStimulus(0, 8'(p), 0);
            end
            begin
                seen = 0;
                for (int n = 0; n < 100 && !seen; n++) begin
                    @(posedge clk); #1;
                    if (mVld[0]) seen = 1;
                end
                if (!seen) checkOutput("bp_first_valid_timeout", 72'd0, 72'd1);
                mRdy[0] = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                mRdy[0] = 1'b1;
            end
        join
        waitDrain(0);
        checkOutput("bp_count", winCnt[0] - base, 4);

        $display("[TB] back-to-back frames");
        base = winCnt[0];
        for (int p = 0; p < 32; p++) applyStimulus(0, 8'(p), 0);
        waitDrain(0);
        checkOutput("b2b_count", winCnt[0] - base, 8);

        $display("[TB] reset mid-frame");
        for (int p = 0; p < 10; p++) applyStimulus(0, 8'(p), 0);
        doReset();
        mRdy[0] = 1'b0;
        for (int p = 0; p < 11; p++) applyStimulus(0, 8'(p), 0);
        doReset();
        mRdy[0] = 1'b1;
        base = winCnt[0];
        for (int p = 0; p < 16; p++) applyStimulus(0, 8'(p), 0);
        waitDrain(0);
        checkOutput("post_reset_count", winCnt[0] - base, 4);

        $display("[TB] random 6x5 traffic");
        base = winCnt[1];
        randOn = 1'b1;
        for (int p = 0; p < 60; p++) applyStimulus(1, 8'($urandom_range(255)), 50);
        randOn  = 1'b0;
        @(posedge clk); #1;
        mRdy[1] = 1'b1;
        waitDrain(1);
        checkOutput("random_count", winCnt[1] - base, 24);

        $display("[TB] three frames");
        doReset();
        base = winCnt[0];
        for (int p = 0; p < 48; p++) applyStimulus(0, 8'($urandom_range(255)), 0);
        waitDrain(0);
        checkOutput("three_frame_count", winCnt[0] - base, 12);
`ifdef WIN_FRAME_CNT_EN
        @(posedge clk); #1;
        checkOutput("frame_cnt_final", bus4.frame_cnt, frameExp);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv3x3_window_gen.md
Name: conv3x3_window_gen

Overview:
- Producer side of the 3x3 kernel interface. Accepts a raster-order pixel stream and builds the nine-pixel neighbourhood (win00..win22) that feeds the gauss blur kernel.
- Holds the two previous image rows in line buffers and a 3x3 shift window.
- Emits one window per interior pixel over a valid/ready handshake.
- Sits between the pixel source (camera/DMA) and the gauss kernel array.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_WIDTH, 640: pixels per row; minimum 3.
- IMG_HEIGHT, 480: rows per frame; minimum 3.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- s_pixel  in  DATA_W  input pixel, raster order, row-major.
- s_valid  in  1  s_pixel valid.
- s_ready  out  1  block can accept s_pixel this cycle.
- win00, win01, win02  out  DATA_W each  window row r-2, cols c-2, c-1, c.
- win10, win11, win12  out  DATA_W each  window row r-1, cols c-2, c-1, c.
- win20, win21, win22  out  DATA_W each  window row r, cols c-2, c-1, c.
- m_valid  out  1  window outputs valid.
- m_ready  in  1  downstream accepts the window.
- m_last  out  1  window is the final window of the frame (r=IMG_HEIGHT-1, c=IMG_WIDTH-1).

Behaviour:
- Reset (rst_n=0, asynchronous): col=0, row=0, m_valid=0, m_last=0, all win* outputs=0, shift window cleared. Line buffer contents are don't-care. s_ready=1 from the first cycle after release.
- Handshake rules:
  - s_ready = ~m_valid | m_ready, combinational.
  - A pixel is accepted when s_valid & s_ready.
  - A window is consumed when m_valid & m_ready.
  - Output holds stable while m_valid & ~m_ready.
- Position counters:
  - col increments on each accepted pixel and wraps at IMG_WIDTH-1 to 0; a wrap increments row.
  - row wraps at IMG_HEIGHT-1 to 0 (new frame). No gap between frames.
- Line buffers:
  - Two RAMs of IMG_WIDTH x DATA_W: lb_a holds row r-1, lb_b holds row r-2.
  - On an accepted pixel at column c: read lb_a[c] and lb_b[c]; write lb_b[c] <= lb_a[c] and lb_a[c] <= s_pixel.
  - Reading old data in the same cycle as the write is required (read-before-write).
- Shift window:
  - On an accepted pixel, each window row shifts left by one: col0 <= col1 <= col2.
  - The new column is {lb_b[c], lb_a[c], s_pixel}, landing in column 2.
- Output register:
  - If the accepted pixel has row>=2 and col>=2, the window register loads the post-shift window one cycle later, with m_valid=1.
  - m_last=1 iff that pixel is at (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Latency from accepted pixel to m_valid is 1 cycle.
- Borders: pixels in rows 0-1 or columns 0-1 produce no window and apply no padding. Each frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- Empty pixel/consumed window: if no window-producing pixel is accepted in a cycle where the window is consumed, m_valid drops to 0. Simultaneous consume and new window: m_valid stays 1 with the new data.
- Row boundary: the window at col 2 uses only the current row's columns 0-2; no stale data from the previous row reaches the output.
- Reset mid-frame: counters return to (0,0) and any pending window is discarded. The next accepted pixel is treated as the top-left pixel of a new frame.

Optional Feature:
- Macro WIN_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt (16 bits), reset to 0.
  - frame_cnt increments by 1 when the window with m_last=1 is consumed, and wraps at 16'hFFFF to 0.
  - Adds output port m_first, high with the first window of each frame (row=2, col=2).
- When undefined: neither port exists, and no counter logic is present.

Test Plan:
- Basic 4x4 frame (IMG_WIDTH=4, IMG_HEIGHT=4), pixels 0..15, s_valid=1, m_ready=1 -> exactly 4 windows.
  - First window (after pixel 10): win00..win22 = 0,1,2,4,5,6,8,9,10.
  - Last window: 5,6,7,9,10,11,13,14,15, with m_last=1 on that window only.
- Backpressure: same frame, m_ready=0 for 5 cycles after the first m_valid -> s_ready=0 while m_valid held; window 0,1,2,4,5,6,8,9,10 stable; no pixel lost; remaining 3 windows correct.
- Back-to-back frames: 32 pixels (two 4x4 frames, values 0..31) -> 8 windows. Frame-2 first window = 16,17,18,20,21,22,24,25,26, with no row-boundary corruption.
- Reset mid-frame: assert rst_n=0 after pixel 9 -> m_valid=0 immediately; then a new frame of 0..15 yields the same 4 windows as the basic test.
- Random s_valid gaps (50%) and random m_ready on a 6x5 frame -> 12 windows, matching the reference model in order.
- With WIN_FRAME_CNT_EN: three 4x4 frames -> frame_cnt goes 0 to 1 to 2 to 3; m_first high on exactly 3 windows.
